muldiv_ctrl: RTL

- Multi-cycle sequencer for the HI/LO multiply/divide resource beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the CPU control path.
- Runs a fixed-latency multiply wait or a 32-step restoring divider, then writes HI/LO.
- Drives a busy/stall signal so MFHI/MFLO and back-to-back mul/div wait for valid results.

---
 rtl/muldiv_ctrl_pkg.sv | 22 ++
 rtl/muldiv_ctrl_if.sv | 27 ++
 rtl/muldiv_ctrl_div_step.sv | 26 ++
 rtl/muldiv_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// Command codes, FSM states and divider step count.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int DIV_STEPS = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Command/result bundle between the CPU control path
// and the HI/LO multiply/divide sequencer.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             iStart;
  logic [2:0]       iOp;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic [WIDTH-1:0] oHI;
  logic [WIDTH-1:0] oLO;
  logic             oBusy;
  logic             oDone;
  logic             oDivZero;

  modport master (
    output iStart, iOp, iA, iB,
    input  oHI, oLO, oBusy, oDone, oDivZero
  );

  modport slave (
    input  iStart, iOp, iA, iB,
    output oHI, oLO, oBusy, oDone, oDivZero
  );

endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division step: shift {rem,quo} left,
// trial-subtract the divisor, keep it if non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;
  logic           ok;

  // one extra bit: the shifted remainder can exceed WIDTH bits
  always_comb begin
    sh    = {rem_i, quo_i[WIDTH-1]};
    diff  = sh - {1'b0, div_i};
    ok    = ~diff[WIDTH];
    rem_o = ok ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], ok};
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply,
// 32-step restoring divide, MTHI/MTLO, busy/done handshake.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic iCLK,
  input  logic iRST,
  muldiv_ctrl_if.slave bus
);

  localparam int MAXC =
    (MUL_LATENCY > DIV_STEPS) ? MUL_LATENCY : DIV_STEPS;
  localparam int CW = $clog2(MAXC) + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0]   st_rem;
  logic [WIDTH-1:0]   st_quo;
  logic [2*WIDTH-1:0] ax, bx, prod;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               take;
  logic               op_mul, op_div;
  logic               op_sgn, b_zero;

  // a_q doubles as the dividend/quotient shift register
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (a_q),
    .div_i (b_q),
    .rem_o (st_rem),
    .quo_o (st_quo)
  );

  always_comb begin
    ax   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q}
                 : {{WIDTH{1'b0}}, a_q};
    bx   = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q}
                 : {{WIDTH{1'b0}}, b_q};
    prod = ax * bx;
  end

  always_comb begin
    take   = bus.iStart &&
             (state_q == S_IDLE || state_q == S_DONE);
    op_mul = bus.iOp == OP_MULT || bus.iOp == OP_MULTU;
    op_div = bus.iOp == OP_DIV || bus.iOp == OP_DIVU;
    op_sgn = bus.iOp == OP_MULT || bus.iOp == OP_DIV;
    b_zero = bus.iB == '0;
    a_abs  = (op_sgn && bus.iA[WIDTH-1]) ? -bus.iA : bus.iA;
    b_abs  = (op_sgn && bus.iB[WIDTH-1]) ? -bus.iB : bus.iB;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;

    case (state_q)
      S_MUL: begin
        if (cnt_q == '0) begin
          {hi_d, lo_d} = prod;
          state_d      = S_DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        rem_d = st_rem;
        a_d   = st_quo;
        if (cnt_q == '0) state_d = S_FIX;
        else cnt_d = cnt_q - 1'b1;
      end
      S_FIX: begin
        lo_d    = qneg_q ? -a_q : a_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: ;
    endcase

    if (take) begin
      unique case (1'b1)
        bus.iOp == OP_MTHI: hi_d = bus.iA;
        bus.iOp == OP_MTLO: lo_d = bus.iA;
        op_mul: begin
          a_d     = bus.iA;
          b_d     = bus.iB;
          sgn_d   = op_sgn;
          cnt_d   = CW'(MUL_LATENCY - 1);
          state_d = S_MUL;
          busy_d  = 1'b1;
        end
        op_div && !b_zero: begin
          a_d     = a_abs;
          b_d     = b_abs;
          rem_d   = '0;
          qneg_d  = op_sgn && (bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1]);
          rneg_d  = op_sgn && bus.iA[WIDTH-1];
          cnt_d   = CW'(DIV_STEPS - 1);
          state_d = S_DIV;
          busy_d  = 1'b1;
        end
        op_div && b_zero: begin
          hi_d    = bus.iA;
          lo_d    = '1;
          state_d = S_DONE;
          done_d  = 1'b1;
          dz_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.oHI      = hi_q;
  assign bus.oLO      = lo_q;
  assign bus.oBusy    = busy_q;
  assign bus.oDone    = done_q;
  assign bus.oDivZero = dz_q;

endmodule
